// File: rtl/pipelined_add_sub_pkg.sv
// Shared constants for the pipelined adder/subtractor: operation encodings,
// Flags bit positions and the slice-0 carry-in rule.
`ifndef PIPELINED_ADD_SUB_DEFS
`define PIPELINED_ADD_SUB_DEFS
`define PAS_OP_ADD  2'b00
`define PAS_OP_SUB  2'b01
`define PAS_OP_ADC  2'b10
`define PAS_OP_SBB  2'b11
`define PAS_FLAG_C  3
`define PAS_FLAG_V  2
`define PAS_FLAG_N  1
`define PAS_FLAG_Z  0
`endif

package pipelined_add_sub_pkg;

    typedef enum logic [1:0] {
        OP_ADD = `PAS_OP_ADD,
        OP_SUB = `PAS_OP_SUB,
        OP_ADC = `PAS_OP_ADC,
        OP_SBB = `PAS_OP_SBB
    } op_e;

    localparam int unsigned FLAG_C = `PAS_FLAG_C;
    localparam int unsigned FLAG_V = `PAS_FLAG_V;
    localparam int unsigned FLAG_N = `PAS_FLAG_N;
    localparam int unsigned FLAG_Z = `PAS_FLAG_Z;

    // Plain add/sub use Op[0] as carry-in (0 for add, 1 for two's-complement
    // subtract); the chained forms take the external Cin instead.
    function automatic logic slice0_carry(input logic [1:0] op, input logic cin);
        return op[1] ? cin : op[0];
    endfunction

endpackage

// File: rtl/pipelined_add_sub_if.sv
// Operand/result handshake bundle for pipelined_add_sub.
interface pipelined_add_sub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [1:0]       Op;
    logic             Cin;
    logic             Sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic [3:0]       Flags;

    modport master (
        output in_valid, A, B, Op, Cin, Sat, out_ready,
        input  in_ready, out_valid, Sum, Flags
    );

    modport slave (
        input  in_valid, A, B, Op, Cin, Sat, out_ready,
        output in_ready, out_valid, Sum, Flags
    );
endinterface

// File: rtl/pipelined_add_sub_cla_slice.sv
// Carry-look-ahead adder slice: GROUP-bit look-ahead groups chained by their
// group carries.
module cla_slice #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] sum,
    output logic             co
);
    localparam int unsigned NGROUP = WIDTH / GROUP;

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;
    logic             pre_g;
    logic             pre_p;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Every bit carry is a prefix (generate, propagate) of its group applied to
    // the group carry-in, so only group carries chain between groups.
    always_comb begin
        carry    = '0;
        carry[0] = ci;
        pre_g    = 1'b0;
        pre_p    = 1'b1;
        for (int unsigned n = 0; n < NGROUP; n++) begin
            pre_g = 1'b0;
            pre_p = 1'b1;
            for (int unsigned i = 0; i < GROUP; i++) begin
                pre_g = gen[n*GROUP+i] | (prop[n*GROUP+i] & pre_g);
                pre_p = pre_p & prop[n*GROUP+i];
                carry[n*GROUP+i+1] = pre_g | (pre_p & carry[n*GROUP]);
            end
        end
    end

    assign sum = prop ^ carry[WIDTH-1:0];
    assign co  = carry[WIDTH];
endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined add/subtract with optional signed saturation. Stage k adds slice k
// using the carry registered by stage k-1; the last stage also forms the flags
// and the saturated result. Each stage holds one beat with valid/ready flow.
module pipelined_add_sub
    import pipelined_add_sub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input logic                clk,
    input logic                rst,
    pipelined_add_sub_if.slave bus
);
    localparam int          SLICE = WIDTH / STAGES;
    localparam int unsigned LAST  = STAGES - 1;
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Registered stage state
    logic [STAGES-1:0] vld_q;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  bx_q  [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic              c_q   [STAGES];
    logic              sat_q [STAGES];
    logic [3:0]        flags_q;

    // Values presented to each stage by its upstream neighbour
    logic [STAGES-1:0] vld_d;
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  bx_d  [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic              c_d   [STAGES];
    logic              sat_d [STAGES];

    logic [SLICE-1:0]  s_slice  [STAGES];
    logic              co_slice [STAGES];
    logic [WIDTH-1:0]  sum_n    [STAGES];
    logic [STAGES-1:0] rdy;

    logic [WIDTH-1:0]  res;
    logic [3:0]        flags_n;
    logic              cmsb;
    logic              ovf;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign vld_d[k] = bus.in_valid;
            assign a_d[k]   = bus.A;
            assign bx_d[k]  = bus.B ^ {WIDTH{bus.Op[0]}};
            assign sum_d[k] = '0;
            assign c_d[k]   = slice0_carry(bus.Op, bus.Cin);
            assign sat_d[k] = bus.Sat;
        end else begin : g_tail
            assign vld_d[k] = vld_q[k-1];
            assign a_d[k]   = a_q[k-1];
            assign bx_d[k]  = bx_q[k-1];
            assign sum_d[k] = sum_q[k-1];
            assign c_d[k]   = c_q[k-1];
            assign sat_d[k] = sat_q[k-1];
        end

        cla_slice #(
            .WIDTH (SLICE),
            .GROUP (GROUP)
        ) u_cla (
            .a   (a_d[k][k*SLICE +: SLICE]),
            .b   (bx_d[k][k*SLICE +: SLICE]),
            .ci  (c_d[k]),
            .sum (s_slice[k]),
            .co  (co_slice[k])
        );
    end

    // Ready ripples back from the consumer: a stage may load when it is empty
    // or its occupant moves on this cycle.
    always_comb begin
        rdy       = '0;
        rdy[LAST] = ~vld_q[LAST] | bus.out_ready;
        for (int unsigned i = 1; i < STAGES; i++) begin
            rdy[STAGES-1-i] = ~vld_q[STAGES-1-i] | rdy[STAGES-i];
        end
    end

    // Merge each stage's fresh slice into the partial result it forwards.
    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            sum_n[k] = sum_d[k];
            sum_n[k][k*SLICE +: SLICE] = s_slice[k];
        end
    end

    // Final stage: overflow from the MSB carries, saturation, then N/Z on the
    // saturated value. Carry into the MSB is recovered as a ^ b ^ sum there.
    always_comb begin
        res  = sum_n[LAST];
        cmsb = a_d[LAST][WIDTH-1] ^ bx_d[LAST][WIDTH-1] ^ sum_n[LAST][WIDTH-1];
        ovf  = cmsb ^ co_slice[LAST];
        if (sat_d[LAST] && ovf) begin
            res = a_d[LAST][WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
        flags_n         = '0;
        flags_n[FLAG_C] = co_slice[LAST];
        flags_n[FLAG_V] = ovf;
        flags_n[FLAG_N] = res[WIDTH-1];
        flags_n[FLAG_Z] = (res == '0);
    end

    // Stage registers: load on ready, payload only when a real beat arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= '0;
            flags_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                bx_q[k]  <= '0;
                sum_q[k] <= '0;
                c_q[k]   <= 1'b0;
                sat_q[k] <= 1'b0;
            end
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    vld_q[k] <= vld_d[k];
                    if (vld_d[k]) begin
                        a_q[k]   <= a_d[k];
                        bx_q[k]  <= bx_d[k];
                        c_q[k]   <= co_slice[k];
                        sat_q[k] <= sat_d[k];
                        if (k == LAST) begin
                            sum_q[k] <= res;
                        end else begin
                            sum_q[k] <= sum_n[k];
                        end
                    end
                end
            end
            if (rdy[LAST] && vld_d[LAST]) begin
                flags_q <= flags_n;
            end
        end
    end

    assign bus.in_ready  = rdy[0] & ~rst;
    assign bus.out_valid = vld_q[LAST];
    assign bus.Sum       = sum_q[LAST];
    assign bus.Flags     = flags_q;
endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub (WIDTH=32, STAGES=2): directed vector table,
// 64-bit carry chain, backpressure run and mid-flight reset.
module tb_pipelined_add_sub;
    import pipelined_add_sub_pkg::*;

    localparam int STAGES = 2;

    typedef struct {
        logic [1:0]  op;
        logic        cin;
        logic        sat;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic [3:0]  flags;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    vec_t        vecs [16];
    logic [31:0] got_sum;
    logic [3:0]  got_flags;
    int          got_lat;
    logic [31:0] lo_sum;
    logic [3:0]  lo_flags;
    logic [31:0] hi_sum;
    logic [3:0]  hi_flags;
    logic [63:0] a64;
    logic [63:0] b64;
    logic [35:0] exp_beat;
    int          sent;
    int          rcvd;
    int          inflight;
    logic        acc;
    logic        drn;
    logic        stalled;
    logic [31:0] hold_sum;
    logic [3:0]  hold_flags;

    pipelined_add_sub_if #(.WIDTH(32)) bus ();

    pipelined_add_sub #(
        .WIDTH  (32),
        .GROUP  (4),
        .STAGES (STAGES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Independent reference: 33-bit arithmetic, overflow from operand/result signs.
    function automatic logic [35:0] ref_calc(input logic [1:0] op, input logic cin, input logic sat,
                                             input logic [31:0] a, input logic [31:0] b);
        logic [32:0] t;
        logic [31:0] bb;
        logic [31:0] s;
        logic        c0;
        logic        v;
        bb = op[0] ? ~b : b;
        c0 = op[1] ? cin : op[0];
        t  = {1'b0, a} + {1'b0, bb} + {32'd0, c0};
        s  = t[31:0];
        v  = (a[31] == bb[31]) && (s[31] != a[31]);
        if (sat && v) s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return {t[32], v, s[31], (s == 32'd0), s};
    endfunction

    function automatic logic [31:0] beat_a(input int i);
        return 32'h1111_1111 * 32'(i + 1);
    endfunction

    function automatic logic [31:0] beat_b(input int i);
        return 32'h0303_0303 + 32'(i);
    endfunction

    function automatic logic [1:0] beat_op(input int i);
        return (i % 2 == 1) ? OP_SUB : OP_ADD;
    endfunction

    // One beat through an otherwise idle pipe; lat counts rising edges from
    // (and including) the accepting edge until out_valid is seen.
    task automatic run_single(input logic [1:0] op, input logic cin, input logic sat,
                              input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] sum, output logic [3:0] flags, output int lat);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.Op        = op;
        bus.Cin       = cin;
        bus.Sat       = sat;
        bus.A         = a;
        bus.B         = b;
        bus.out_ready = 1'b1;
        #1;
        check("in_ready idle", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        sum   = bus.Sum;
        flags = bus.Flags;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        vecs[0]  = '{OP_ADD, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1001};
        vecs[1]  = '{OP_SUB, 1'b0, 1'b0, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 4'b0010};
        vecs[2]  = '{OP_ADD, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0100};
        vecs[3]  = '{OP_ADD, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0110};
        vecs[4]  = '{OP_SUB, 1'b0, 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 4'b1110};
        vecs[5]  = '{OP_SUB, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b1100};
        vecs[6]  = '{OP_ADC, 1'b1, 1'b0, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0001, 4'b0000};
        vecs[7]  = '{OP_ADC, 1'b0, 1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 4'b0000};
        vecs[8]  = '{OP_SBB, 1'b1, 1'b0, 32'h0000_000A, 32'h0000_0003, 32'h0000_0007, 4'b1000};
        vecs[9]  = '{OP_SBB, 1'b0, 1'b0, 32'h0000_000A, 32'h0000_0003, 32'h0000_0006, 4'b1000};
        vecs[10] = '{OP_SUB, 1'b0, 1'b0, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 4'b1001};
        vecs[11] = '{OP_SUB, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b0010};
        vecs[12] = '{OP_ADD, 1'b0, 1'b0, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 4'b0000};
        vecs[13] = '{OP_ADD, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 4'b1110};
        vecs[14] = '{OP_ADD, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 4'b1101};
        vecs[15] = '{OP_ADD, 1'b1, 1'b1, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 4'b0000};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.Op        = OP_ADD;
        bus.Cin       = 1'b0;
        bus.Sat       = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", 64'(bus.in_ready), 64'd0);
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset Sum", 64'(bus.Sum), 64'd0);
        check("reset Flags", 64'(bus.Flags), 64'd0);
        rst = 1'b0;
        #1;
        check("release in_ready", 64'(bus.in_ready), 64'd1);

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            run_single(vecs[i].op, vecs[i].cin, vecs[i].sat, vecs[i].a, vecs[i].b,
                       got_sum, got_flags, got_lat);
            check($sformatf("vec%0d latency", i), 64'(got_lat), 64'(STAGES));
            check($sformatf("vec%0d Sum", i), 64'(got_sum), 64'(vecs[i].sum));
            check($sformatf("vec%0d Flags", i), 64'(got_flags), 64'(vecs[i].flags));
        end

        // 64-bit add-with-carry over two beats
        a64 = 64'h0123_4567_FFFF_FFFF;
        b64 = 64'h0000_0001_0000_0001;
        run_single(OP_ADC, 1'b0, 1'b0, a64[31:0], b64[31:0], lo_sum, lo_flags, got_lat);
        check("chain low carry", 64'(lo_flags[3]), 64'd1);
        run_single(OP_ADC, lo_flags[3], 1'b0, a64[63:32], b64[63:32], hi_sum, hi_flags, got_lat);
        check("chain 64-bit sum", {hi_sum, lo_sum}, a64 + b64);

        // Eight back-to-back beats, consumer stalls in cycles 3..5
        sent     = 0;
        rcvd     = 0;
        inflight = 0;
        stalled  = 1'b0;
        for (int cyc = 0; cyc < 40 && rcvd < 8; cyc++) begin
            @(negedge clk);
            bus.out_ready = !(cyc >= 3 && cyc <= 5);
            bus.Cin       = 1'b0;
            bus.Sat       = 1'b0;
            if (sent < 8) begin
                bus.in_valid = 1'b1;
                bus.A        = beat_a(sent);
                bus.B        = beat_b(sent);
                bus.Op       = beat_op(sent);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            check($sformatf("bp cyc%0d in_ready", cyc), 64'(bus.in_ready),
                  64'(!(inflight == STAGES && !bus.out_ready)));
            if (stalled) begin
                check($sformatf("bp cyc%0d hold valid", cyc), 64'(bus.out_valid), 64'd1);
                check($sformatf("bp cyc%0d hold Sum", cyc), 64'(bus.Sum), 64'(hold_sum));
                check($sformatf("bp cyc%0d hold Flags", cyc), 64'(bus.Flags), 64'(hold_flags));
            end
            stalled    = bus.out_valid && !bus.out_ready;
            hold_sum   = bus.Sum;
            hold_flags = bus.Flags;
            acc = bus.in_valid && bus.in_ready;
            drn = bus.out_valid && bus.out_ready;
            if (drn) begin
                exp_beat = ref_calc(beat_op(rcvd), 1'b0, 1'b0, beat_a(rcvd), beat_b(rcvd));
                check($sformatf("bp beat%0d Sum", rcvd), 64'(bus.Sum), 64'(exp_beat[31:0]));
                check($sformatf("bp beat%0d Flags", rcvd), 64'(bus.Flags), 64'(exp_beat[35:32]));
                rcvd++;
            end
            @(posedge clk);
            if (acc) sent++;
            inflight = inflight + (acc ? 1 : 0) - (drn ? 1 : 0);
        end
        check("bp beats received", 64'(rcvd), 64'd8);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("bp no duplicate %0d", i), 64'(bus.out_valid), 64'd0);
        end

        // Reset with two beats in flight
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.Op        = OP_ADD;
        bus.A         = 32'h0000_1000;
        bus.B         = 32'h0000_0234;
        @(posedge clk);
        @(negedge clk);
        bus.A = 32'h0000_2000;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("flight out_valid", 64'(bus.out_valid), 64'd1);
        check("flight Sum", 64'(bus.Sum), 64'h1234);
        rst = 1'b1;
        #1;
        check("rst in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("post-rst out_valid", 64'(bus.out_valid), 64'd0);
        check("post-rst Sum", 64'(bus.Sum), 64'd0);
        check("post-rst Flags", 64'(bus.Flags), 64'd0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("post-rst in_ready", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("no stale %0d", i), 64'(bus.out_valid), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pipelined_add_sub.md
PIPELINED_ADD_SUB -- requirements
Module: pipelined_add_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width, a multiple of STAGES*GROUP.
REQ-002 SHALL have parameter GROUP, default 4: carry-look-ahead group width in bits.
REQ-003 SHALL have parameter STAGES, default 2: pipeline depth, with 1 <= STAGES <= WIDTH/GROUP.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1: the operand beat is valid.
REQ-007 SHALL have port in_ready, output, 1: the block accepts the beat this cycle.
REQ-008 SHALL have port A, input, WIDTH: operand A.
REQ-009 SHALL have port B, input, WIDTH: operand B.
REQ-010 SHALL have port Op, input, 2: operation select; 00 A+B, 01 A-B, 10 A+B+Cin, 11 A-B-!Cin (borrow chain).
REQ-011 SHALL have port Cin, input, 1: carry-in used by Op 10 and 11.
REQ-012 SHALL have port Sat, input, 1: selects signed saturation of the result.
REQ-013 SHALL have port out_valid, output, 1: the result beat is valid.
REQ-014 SHALL have port out_ready, input, 1: the consumer takes the beat.
REQ-015 SHALL have port Sum, output, WIDTH: the result.
REQ-016 SHALL have port Flags, output, 4: {CarryOut, Overflow, Negative, Zero}.

Function
REQ-017 SHALL invert B with an XOR mask when Op[0]=1; slice-0 carry-in SHALL be Op[0] for Op 0x and Cin for Op 1x.
REQ-018 SHALL split the WIDTH bits into STAGES equal slices; stage k SHALL compute slice k, using the carry registered from stage k-1, and SHALL forward the upper operand bits unchanged.
REQ-019 SHALL have a latency of exactly STAGES cycles from the accepting edge to out_valid with no backpressure.
REQ-020 SHALL hold one beat in each stage; a stage SHALL advance when the next stage is empty or advancing; the last stage SHALL advance when out_ready=1.
REQ-021 SHALL drive in_ready=1 whenever stage 0 is empty or advancing, giving a throughput of 1 beat/cycle.
REQ-022 SHALL keep Sum, Flags and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL set CarryOut to the final carry, which is the raw carry of the inverted-B addition (1 means no borrow).
REQ-024 SHALL set Overflow = carry into MSB XOR carry out of MSB.
REQ-025 SHALL, when Sat=1 and Overflow=1, set Sum to 0x7FF..F if the operand-A sign is 0, else 0x800..0; Overflow SHALL remain reported.
REQ-026 SHALL set Negative = Sum[WIDTH-1] and Zero = (Sum==0), both after saturation.
REQ-027 SHALL carry Op, Cin and Sat with the beat, so that per-beat mode changes never corrupt beats in flight.
REQ-028 SHALL, when in_valid=1 and out_ready toggles in the same cycle, apply acceptance and drain without losing or duplicating any beat.

Reset
REQ-029 SHALL, with rst=1 at a clock edge, clear every stage valid bit, out_valid and Flags, and set Sum to 0.
REQ-030 SHALL discard in-flight beats when reset is asserted mid-operation; in_ready SHALL be 0 while rst=1 and 1 in the first cycle after release.

Structure
REQ-031 SHALL place the Op encodings and the Flags bit indices in a shared include file of `define constants.
REQ-032 SHALL use one sub-module, cla_slice, parametrised by slice width and GROUP, producing sum and carry-out from a, b and ci; generate loops SHALL instantiate it per stage.

Verification
REQ-033 SHALL cover: WIDTH=32, STAGES=2, Op=00, A=0xFFFFFFFF, B=1 -> after 2 cycles Sum=0, Flags=1001.
REQ-034 SHALL cover: Op=01, A=5, B=7 -> Sum=0xFFFFFFFE, Flags=0010.
REQ-035 SHALL cover: Sat=1, Op=00, A=0x7FFFFFFF, B=1 -> Sum=0x7FFFFFFF, Flags=0100; with Sat=0 -> Sum=0x80000000, Flags=0110.
REQ-036 SHALL cover: back-to-back 8 beats with out_ready low for cycles 3-5 -> all 8 results in order, no drop/duplicate, in_ready low only while full.
REQ-037 SHALL cover: 64-bit add-with-carry chain, Op=10, Cin=previous CarryOut over two beats -> equals a 64-bit reference sum.
REQ-038 SHALL cover: rst asserted with 2 beats in flight -> out_valid=0 on the next cycle, no stale result after release.
